// File: rtl/nrzm_pkg.sv
// Shared constants, state encoding and helpers for the NRZ-M frame receiver.
package nrzm_pkg;

    localparam logic [31:0] ASM_WORD      = 32'h1ACFFC1D;
    localparam int          ASM_LEN       = 32;
    localparam int          PAYLOAD_BYTES = 146;

    typedef enum logic [1:0] {
        HUNT,
        LOCK,
        CHECK
    } state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nrzm_bit_sync.sv
// Line synchronizer, edge-aligned bit timing recovery and NRZ-M decode.
// Emits one registered data_bit/bit_strobe pair per recovered bit period.
module nrzm_bit_sync #(
    parameter int PERIOD = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic phase_in,
    output logic data_bit,
    output logic bit_strobe
);

    localparam int            CW         = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(PERIOD / 2);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev_sample;
    logic          line_edge;

    assign line_edge = sync[1] ^ sync[0];

    // NOTE: every register in a clocked block is assigned with <= so all flops
    // update from pre-edge values; blocking here would chain sync[0] into sync[1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            cnt         <= '0;
            prev_sample <= 1'b1;
            data_bit    <= 1'b0;
            bit_strobe  <= 1'b0;
        end else begin
            sync       <= {sync[0], phase_in};
            bit_strobe <= 1'b0;

            // A line edge re-centres the grid so the sample lands mid-bit.
            if (line_edge || cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (cnt == CNT_SAMPLE) begin
                data_bit    <= sync[1] ^ prev_sample;
                prev_sample <= sync[1];
                bit_strobe  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nrzm_frame_rx.sv
// NRZ-M frame receiver: ASM search, flywheel lock tracking and payload
// byte output for fixed 1200-bit frames.
module nrzm_frame_rx
    import nrzm_pkg::*;
#(
    parameter int ref_clk_freq = 128000000,
    parameter int baudrate     = 9600,
    parameter int FRAME_BITS   = 1200,
    parameter int ASM_MAX_ERR  = 0,
    parameter int MISS_LIMIT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phase_in,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        locked,
    output logic        asm_miss,
    output logic [15:0] frame_cnt
);

    localparam int PERIOD       = ref_clk_freq / baudrate + 1;
    localparam int PAYLOAD_BITS = FRAME_BITS - ASM_LEN;
    localparam int BCW          = $clog2(PAYLOAD_BITS);

    if (PAYLOAD_BITS != PAYLOAD_BYTES * 8) begin : g_bad_frame_len
        $error("nrzm_frame_rx: payload must be exactly %0d bytes", PAYLOAD_BYTES);
    end

    logic data_bit;
    logic bit_strobe;

    nrzm_bit_sync #(
        .PERIOD(PERIOD)
    ) u_bit_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .phase_in   (phase_in),
        .data_bit   (data_bit),
        .bit_strobe (bit_strobe)
    );

    state_t           state_q, state_d;
    logic [31:0]      sr_q, sr_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic [4:0]       asm_cnt_q;
    logic [7:0]       miss_cnt_q;
    logic [6:0]       byte_sr_q;
    logic             match;
    logic             take_bit;
    logic             lock_acq;
    logic             asm_pass;
    logic             asm_fail;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        sr_d     = bit_strobe ? {sr_q[30:0], data_bit} : sr_q;
        match    = popcount32(sr_d ^ ASM_WORD) <= 6'(ASM_MAX_ERR);
        take_bit = 1'b0;
        lock_acq = 1'b0;
        asm_pass = 1'b0;
        asm_fail = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (bit_strobe && match) begin
                    state_d  = LOCK;
                    lock_acq = 1'b1;
                end
            end
            LOCK: begin
                if (bit_strobe) begin
                    take_bit = 1'b1;
                    if (bit_cnt_q == BCW'(PAYLOAD_BITS - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (bit_strobe && asm_cnt_q == 5'(ASM_LEN - 1)) begin
                    if (match) begin
                        state_d  = LOCK;
                        asm_pass = 1'b1;
                    end else begin
                        asm_fail = 1'b1;
                        state_d  = ((miss_cnt_q + 8'd1) >= 8'(MISS_LIMIT)) ? HUNT : LOCK;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            asm_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            byte_sr_q   <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            locked      <= 1'b0;
            asm_miss    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            locked      <= (state_d != HUNT);
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            asm_miss    <= asm_fail;

            if (lock_acq || asm_pass) begin
                frame_cnt  <= frame_cnt + 16'd1;
                miss_cnt_q <= '0;
            end else if (asm_fail) begin
                miss_cnt_q <= miss_cnt_q + 8'd1;
            end

            // Every entry into LOCK starts a fresh payload, including flywheel.
            if (state_d == LOCK && state_q != LOCK) begin
                bit_cnt_q <= '0;
                byte_sr_q <= '0;
            end

            if (state_q == LOCK && state_d == CHECK) begin
                asm_cnt_q <= '0;
            end else if (state_q == CHECK && bit_strobe) begin
                asm_cnt_q <= asm_cnt_q + 5'd1;
            end

            if (take_bit) begin
                byte_sr_q <= {byte_sr_q[5:0], data_bit};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q[2:0] == 3'd7) begin
                    byte_valid  <= 1'b1;
                    byte_data   <= {byte_sr_q, data_bit};
                    frame_start <= (bit_cnt_q[BCW-1:3] == '0);
                    frame_end   <= (bit_cnt_q[BCW-1:3] == (BCW-3)'(PAYLOAD_BYTES - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_nrzm_frame_rx.sv
// Self-checking bench: behavioural NRZ-M transmitter, frame-level lock model
// and a byte scoreboard drained by an independent monitor.
module tb_nrzm_frame_rx;
    import nrzm_pkg::*;

    localparam int REF_CLK         = 600;
    localparam int BAUD            = 100;
    localparam int PERIOD          = REF_CLK / BAUD + 1;
    localparam int JITTER          = 1;
    localparam int MAX_ERR         = 2;
    localparam int MISS_LIM        = 2;
    localparam int WATCHDOG_CYCLES = 95000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        phase_in = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        frame_start;
    logic        frame_end;
    logic        locked;
    logic        asm_miss;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    nrzm_frame_rx #(
        .ref_clk_freq (REF_CLK),
        .baudrate     (BAUD),
        .FRAME_BITS   (1200),
        .ASM_MAX_ERR  (MAX_ERR),
        .MISS_LIMIT   (MISS_LIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_in    (phase_in),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .asm_miss    (asm_miss),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       fs;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   popped    = 0;
    int   miss_seen = 0;

    bit m_locked      = 1'b0;
    int m_misses      = 0;
    int m_frame_cnt   = 0;
    int m_miss_pulses = 0;

    bit tx_level = 1'b1;
    bit invert   = 1'b0;
    bit jit_en   = 1'b0;
    int cur_j    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (asm_miss === 1'b1) miss_seen++;
        if (byte_valid === 1'b1) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            check("locked_at_byte", 32'(locked), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("byte_data", 32'(byte_data), 32'(e.data));
                check("frame_start", 32'(frame_start), 32'(e.fs));
                check("frame_end", 32'(frame_end), 32'(e.fe));
            end
            popped++;
        end
    end

    initial begin : watchdog
        repeat (WATCHDOG_CYCLES) @(posedge clk);
        $display("FAIL watchdog actual=timeout expected=finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // One NRZ-M symbol: a 1 toggles the line; each edge is displaced by jitter.
    task automatic send_bit(input bit b);
        int nj;
        int dur;
        if (b) tx_level = ~tx_level;
        phase_in = tx_level ^ invert;
        nj    = jit_en ? (int'($urandom_range(2 * JITTER)) - JITTER) : 0;
        dur   = PERIOD + nj - cur_j;
        cur_j = nj;
        repeat (dur) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_misses    = 0;
        m_frame_cnt = 0;
    endtask

    task automatic send_frame(input int nflip);
        logic [7:0]  pl [PAYLOAD_BYTES];
        logic [31:0] mask;
        logic [31:0] asm_tx;
        bit          expect_out;

        pl[0] = 8'hFF;
        pl[1] = 8'h48;
        pl[PAYLOAD_BYTES-1] = 8'h77;
        for (int i = 2; i < PAYLOAD_BYTES - 1; i++) pl[i] = 8'($urandom_range(255));

        mask = '0;
        while ($countones(mask) < nflip) mask[$urandom_range(31)] = 1'b1;
        asm_tx = ASM_WORD ^ mask;

        if (!m_locked) begin
            expect_out = (nflip <= MAX_ERR);
            if (expect_out) begin
                m_locked = 1'b1;
                m_misses = 0;
                m_frame_cnt++;
            end
        end else if (nflip <= MAX_ERR) begin
            expect_out = 1'b1;
            m_misses   = 0;
            m_frame_cnt++;
        end else begin
            m_miss_pulses++;
            m_misses++;
            if (m_misses >= MISS_LIM) begin
                m_locked   = 1'b0;
                expect_out = 1'b0;
            end else begin
                expect_out = 1'b1;
            end
        end

        if (expect_out) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++)
                exp_q.push_back('{data: pl[i], fs: (i == 0), fe: (i == PAYLOAD_BYTES - 1)});
        end

        for (int b = 31; b >= 0; b--) send_bit(asm_tx[b]);
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (i == 2) begin
                check("locked_after_asm", 32'(locked), 32'(m_locked));
                check("frame_cnt_after_asm", 32'(frame_cnt), 32'(m_frame_cnt));
                check("asm_miss_count", 32'(miss_seen), 32'(m_miss_pulses));
            end
            for (int b = 7; b >= 0; b--) send_bit(pl[i][b]);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_asm_miss"}, 32'(asm_miss), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic finish_scn(input string tag);
        send_idle(10);
        repeat (5) @(negedge clk);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frame_cnt));
        check({tag, "_asm_miss_total"}, 32'(miss_seen), 32'(m_miss_pulses));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    endtask

    initial begin : stimulus
        int base;
        int t;

        // Reset hold, then an idle line must neither lock nor emit bytes.
        repeat (20) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        send_idle(40);
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_bytes", 32'(popped), 32'd0);

        // Clean lock, tolerated 2-bit ASM error, flywheel miss, loss of lock, relock.
        send_frame(0);
        jit_en = 1'b1;
        send_frame(0);
        send_frame(2);
        send_frame(3);
        send_frame(4);
        send_frame(0);
        finish_scn("stream");

        // Inverted line with jitter; asynchronous reset in the middle of a frame.
        invert   = 1'b1;
        phase_in = tx_level ^ invert;
        rst_n    = 1'b0;
        repeat (20) @(negedge clk);
        model_reset();
        exp_q.delete();
        rst_n = 1'b1;
        send_idle(40);
        base = popped;
        fork
            send_frame(0);
            begin
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!(byte_valid === 1'b1 && popped == base + 60) && t < 20000);
                check("reset_point_reached", 32'(popped - base), 32'd60);
                check("frame_cnt_before_reset", 32'(frame_cnt), 32'd1);
                #2 rst_n = 1'b0;
                #1 check_cleared("async_reset");
                exp_q.delete();
                model_reset();
                repeat (20) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        send_frame(0);
        finish_scn("inverted");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
